// File: rtl/mem_arb_pkg.sv
// Shared state encoding and line-address helper for the round-robin memory arbiter.
// PREFETCH/PF_HIT states exist only when MEM_ARB_PREFETCH_EN is defined.
package mem_arb_pkg;

  localparam int DEF_LINE_BYTES = 32;
  localparam int LINE_OFFSET_W  = $clog2(DEF_LINE_BYTES);

`ifdef MEM_ARB_PREFETCH_EN
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SERVE    = 2'd1,
    ST_PREFETCH = 2'd2,
    ST_PF_HIT   = 2'd3
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1
  } arb_state_e;
`endif

  // Clears the byte-offset bits so any address maps onto its cache line.
  function automatic logic [63:0] line_align(input logic [63:0] addr,
                                             input int unsigned off_w);
    return addr & ~((64'd1 << off_w) - 64'd1);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Finds the first set request at or after ptr, wrapping modulo N.
// Purely combinational: zero latency, no backpressure of its own.
module rr_priority_picker #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = PTR_W'((32'(ptr) + 32'(k)) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-client round-robin arbiter onto one memory port; grant 1 cycle after request, resp same cycle as mem_resp.
// Grant held until mem_resp, others wait; MEM_ARB_PREFETCH_EN adds a one-line next-line buffer for PF_CLIENT.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter int LINE_BYTES  = 32,
  parameter int PF_CLIENT   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CLIENTS-1:0]        cl_read,
  input  logic [NUM_CLIENTS-1:0]        cl_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*LINE_W-1:0] cl_wdata,
  output logic [LINE_W-1:0]             cl_rdata,
  output logic [NUM_CLIENTS-1:0]        cl_resp,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [LINE_W-1:0]             mem_wdata,
  input  logic [LINE_W-1:0]             mem_rdata,
  input  logic                          mem_resp
);

  localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int OFF_W = $clog2(LINE_BYTES);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } req_t;

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return ADDR_W'(line_align(64'(a), OFF_W));
  endfunction

  arb_state_e             state, state_nxt;
  logic [PTR_W-1:0]       rr_ptr, grant;
  req_t                   lat, pick_req;
  logic [NUM_CLIENTS-1:0] req_vec;
  logic                   pick_found;
  logic [PTR_W-1:0]       pick_idx;

  assign req_vec = cl_read | cl_write;

  rr_priority_picker #(.N(NUM_CLIENTS), .PTR_W(PTR_W)) u_picker (
    .req   (req_vec),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // A simultaneous read+write from one client is treated as a write.
  always_comb begin
    pick_req.wr    = cl_write[pick_idx];
    pick_req.addr  = align(cl_addr[pick_idx*ADDR_W +: ADDR_W]);
    pick_req.wdata = cl_wdata[pick_idx*LINE_W +: LINE_W];
  end

`ifdef MEM_ARB_PREFETCH_EN
  logic              pf_valid, pf_armed, pf_hit, pf_go;
  logic [ADDR_W-1:0] pf_tag, pf_next;
  logic [LINE_W-1:0] pf_data;

  assign pf_hit = pf_valid && cl_read[PF_CLIENT] && !cl_write[PF_CLIENT] &&
                  (align(cl_addr[PF_CLIENT*ADDR_W +: ADDR_W]) == pf_tag);
  assign pf_go  = pf_armed && !(pf_valid && (pf_tag == pf_next));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
`ifdef MEM_ARB_PREFETCH_EN
        if (pf_hit)          state_nxt = ST_PF_HIT;
        else if (pick_found) state_nxt = ST_SERVE;
        else if (pf_go)      state_nxt = ST_PREFETCH;
`else
        if (pick_found) state_nxt = ST_SERVE;
`endif
      end
      ST_SERVE:    if (mem_resp) state_nxt = ST_IDLE;
`ifdef MEM_ARB_PREFETCH_EN
      ST_PREFETCH: if (mem_resp) state_nxt = ST_IDLE;
      ST_PF_HIT:   state_nxt = ST_IDLE;
`endif
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cl_resp   = '0;
    cl_rdata  = '0;
    case (state)
      ST_SERVE: begin
        mem_read  = !lat.wr;
        mem_write = lat.wr;
        mem_addr  = lat.addr;
        mem_wdata = lat.wr ? lat.wdata : '0;
        if (mem_resp) begin
          cl_resp[grant] = 1'b1;
          cl_rdata       = mem_rdata;
        end
      end
`ifdef MEM_ARB_PREFETCH_EN
      ST_PREFETCH: begin
        mem_read = 1'b1;
        mem_addr = lat.addr;
      end
      ST_PF_HIT: begin
        cl_resp[PF_CLIENT] = 1'b1;
        cl_rdata           = pf_data;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      grant  <= '0;
      lat    <= '0;
    end else begin
      if (state == ST_IDLE && state_nxt == ST_SERVE) begin
        grant <= pick_idx;
        lat   <= pick_req;
      end
      if (state == ST_SERVE && mem_resp)
        rr_ptr <= (grant == PTR_W'(NUM_CLIENTS - 1)) ? '0 : grant + 1'b1;
`ifdef MEM_ARB_PREFETCH_EN
      if (state == ST_IDLE && state_nxt == ST_PREFETCH) begin
        lat.wr    <= 1'b0;
        lat.addr  <= pf_next;
        lat.wdata <= '0;
      end
`endif
    end
  end

`ifdef MEM_ARB_PREFETCH_EN
  // The arm lives for exactly one IDLE cycle: a waiting demand request cancels it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_valid <= 1'b0;
      pf_armed <= 1'b0;
      pf_tag   <= '0;
      pf_next  <= '0;
      pf_data  <= '0;
    end else begin
      if (state == ST_IDLE) pf_armed <= 1'b0;
      if (state == ST_SERVE && mem_resp && !lat.wr && grant == PTR_W'(PF_CLIENT)) begin
        pf_armed <= 1'b1;
        pf_next  <= lat.addr + ADDR_W'(LINE_BYTES);
      end
      if (state == ST_IDLE && state_nxt == ST_SERVE && pick_req.wr && pick_req.addr == pf_tag)
        pf_valid <= 1'b0;
      if (state == ST_PREFETCH && mem_resp) begin
        pf_valid <= 1'b1;
        pf_tag   <= lat.addr;
        pf_data  <= mem_rdata;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: queued expectations of memory ops and client responses, checked by a monitor.
// A bench-side memory answers every op after LAT cycles; prefetch steps compile only with MEM_ARB_PREFETCH_EN.
module tb_mem_arbiter_rr;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int LW  = 256;
  localparam int LAT = 3;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [N-1:0]  resp;
    logic [LW-1:0] rdata;
  } resp_exp_t;

  logic            clk, rst_n;
  logic [N-1:0]    cl_read, cl_write, cl_resp;
  logic [N*AW-1:0] cl_addr;
  logic [N*LW-1:0] cl_wdata;
  logic [LW-1:0]   cl_rdata, mem_wdata, mem_rdata;
  logic            mem_read, mem_write, mem_resp;
  logic [AW-1:0]   mem_addr;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];
  int        errors = 0;
  int        checks = 0;
  logic [N-1:0] done_mask, rearm_now, last_rd, last_wr;
  int        rearm_cnt [N];

  mem_arbiter_rr #(.NUM_CLIENTS(N), .ADDR_W(AW), .LINE_W(LW), .LINE_BYTES(32), .PF_CLIENT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cl_read(cl_read), .cl_write(cl_write), .cl_addr(cl_addr), .cl_wdata(cl_wdata),
    .cl_rdata(cl_rdata), .cl_resp(cl_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
    return {8{a ^ 32'h5A5A_0F0F}};
  endfunction

  function automatic logic [LW-1:0] wpat(input int c, input logic [AW-1:0] a);
    return {8{a ^ 32'hC0DE_0000 ^ 32'(c)}};
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int c, input bit wr, input logic [AW-1:0] a);
    if (wr) cl_write[c] = 1'b1; else cl_read[c] = 1'b1;
    last_wr[c] = wr;
    last_rd[c] = !wr;
    cl_addr[c*AW +: AW]  = a;
    cl_wdata[c*LW +: LW] = wpat(c, a);
  endtask

  task automatic exp_mem(input bit wr, input logic [AW-1:0] a, input int c);
    mem_exp_t e;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = wr ? wpat(c, a) : '0;
    mem_q.push_back(e);
  endtask

  task automatic exp_resp(input int c, input logic [LW-1:0] d);
    resp_exp_t e;
    e.resp    = '0;
    e.resp[c] = 1'b1;
    e.rdata   = d;
    resp_q.push_back(e);
  endtask

  task automatic txn(input int c, input bit wr, input logic [AW-1:0] a);
    exp_mem(wr, a, c);
    exp_resp(c, wr ? '0 : pat(a));
    issue(c, wr, a);
  endtask

  task automatic drain(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 400) begin
      @(negedge clk);
      n++;
      if (mem_q.size() == 0 && resp_q.size() == 0 && (cl_read | cl_write) == '0 &&
          rearm_now == '0 && !(mem_read || mem_write)) quiet++;
      else quiet = 0;
    end
    check({tag, "_drain"}, LW'(quiet >= 3), 1);
    @(posedge clk);
    #1;
  endtask

  // Memory model and client handshake: answer after LAT cycles, drop a request the cycle after its resp.
  initial begin
    int lat_cnt = 0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    done_mask = '0;
    rearm_now = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rearm_now[i]) begin
          cl_read[i]   = last_rd[i];
          cl_write[i]  = last_wr[i];
          rearm_now[i] = 1'b0;
        end
        if (done_mask[i]) begin
          cl_read[i]  = 1'b0;
          cl_write[i] = 1'b0;
          if (rearm_cnt[i] > 0) begin
            rearm_cnt[i]--;
            rearm_now[i] = 1'b1;
          end
        end
      end
      done_mask = '0;
      mem_resp  = 1'b0;
      mem_rdata = '0;
      if (!rst_n || !(mem_read || mem_write)) lat_cnt = 0;
      else begin
        lat_cnt++;
        if (lat_cnt == LAT) begin
          mem_resp  = 1'b1;
          mem_rdata = mem_write ? '0 : pat(mem_addr);
          lat_cnt   = 0;
        end
      end
    end
  end

  // Monitor: pop expectations as the DUT starts memory ops and pulses cl_resp.
  initial begin
    mem_exp_t  cur;
    resp_exp_t re;
    logic busy;
    logic prev_busy = 1'b0;
    logic prev_resp = 1'b0;
    int   busy_cycles = 0;
    forever begin
      @(negedge clk);
      busy = mem_read | mem_write;
      if (prev_resp) check("idle_after_resp", LW'(busy), 0);
      if (busy && !prev_busy) begin
        check("mem_op_expected", LW'(mem_q.size() != 0), 1);
        if (mem_q.size() != 0) begin
          cur = mem_q.pop_front();
          check("mem_write", LW'(mem_write), LW'(cur.wr));
          check("mem_read", LW'(mem_read), LW'(!cur.wr));
          check("mem_addr", LW'(mem_addr), LW'(cur.addr));
          check("mem_wdata", mem_wdata, cur.wdata);
        end
        busy_cycles = 0;
      end
      if (busy) busy_cycles++;
      if (busy && mem_resp) begin
        check("mem_hold_cycles", LW'(busy_cycles), LAT);
        check("mem_addr_stable", LW'(mem_addr), LW'(cur.addr));
      end
      if (cl_resp != '0) begin
        done_mask = done_mask | cl_resp;
        check("resp_expected", LW'(resp_q.size() != 0), 1);
        if (resp_q.size() != 0) begin
          re = resp_q.pop_front();
          check("cl_resp", LW'(cl_resp), LW'(re.resp));
          check("cl_rdata", cl_rdata, re.rdata);
        end
      end
      prev_busy = busy;
      prev_resp = busy && mem_resp;
    end
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    cl_read  = '0;
    cl_write = '0;
    cl_addr  = '0;
    cl_wdata = '0;
    last_rd  = '0;
    last_wr  = '0;
    for (int i = 0; i < N; i++) rearm_cnt[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_read", LW'(mem_read), 0);
    check("rst_mem_write", LW'(mem_write), 0);
    check("rst_mem_addr", LW'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cl_resp", LW'(cl_resp), 0);
    check("rst_cl_rdata", cl_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Lone read from client 1.
    txn(1, 1'b0, 32'h100);
    drain("single_read");

    // Reset mid-transaction, then rr pointer must restart at client 0.
    exp_mem(1'b0, 32'h200, 3);
    issue(3, 1'b0, 32'h200);
    n = 0;
    while (!mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_started", LW'(mem_read), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_read", LW'(mem_read), 0);
    check("rst_mid_cl_resp", LW'(cl_resp), 0);
    cl_read  = '0;
    cl_write = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    txn(0, 1'b1, 32'h300);
    txn(2, 1'b0, 32'h340);
    drain("after_reset");
    txn(3, 1'b0, 32'h380);
    drain("ptr_to_zero");

    // All four clients requesting continuously: two full rotations.
    for (int c = 0; c < N; c++) rearm_cnt[c] = 1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++) begin
        exp_mem(c == 0, 32'h800 + 32'(c) * 32'h20, c);
        exp_resp(c, (c == 0) ? '0 : pat(32'h800 + 32'(c) * 32'h20));
      end
    for (int c = 0; c < N; c++) issue(c, c == 0, 32'h800 + 32'(c) * 32'h20);
    drain("rotation");

    // Simultaneous write (client 0) and read (client 1) with rr at 0.
    txn(0, 1'b1, 32'h40);
    txn(1, 1'b0, 32'h80);
    drain("write_then_read");

    // Read and write together from one client: the write wins.
    txn(2, 1'b1, 32'hC0);
    cl_read[2] = 1'b1;
    drain("rd_wr_both");

    // Request withdrawn mid-flight still completes.
    txn(3, 1'b0, 32'hE0);
    n = 0;
    while (!mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("withdraw_started", LW'(mem_read), 1);
    cl_read[3] = 1'b0;
    drain("withdraw");

`ifdef MEM_ARB_PREFETCH_EN
    // Next-line prefetch then a one-cycle hit with no memory access.
    txn(0, 1'b0, 32'h1000);
    exp_mem(1'b0, 32'h1020, 0);
    drain("pf_fill");
    exp_resp(0, pat(32'h1020));
    issue(0, 1'b0, 32'h1020);
    @(negedge clk);
    check("pf_hit_wait", LW'(cl_resp), 0);
    @(negedge clk);
    check("pf_hit_resp", LW'(cl_resp), 4'b0001);
    check("pf_hit_data", cl_rdata, pat(32'h1020));
    drain("pf_hit");

    // A write to the buffered line invalidates it; the next read misses.
    txn(0, 1'b0, 32'h2000);
    exp_mem(1'b0, 32'h2020, 0);
    drain("pf_fill2");
    txn(1, 1'b1, 32'h2020);
    drain("pf_inval_write");
    txn(0, 1'b0, 32'h2020);
    exp_mem(1'b0, 32'h2040, 0);
    drain("pf_miss");

    // Demand request arriving during a prefetch waits for it.
    txn(0, 1'b0, 32'h3000);
    exp_mem(1'b0, 32'h3020, 0);
    n = 0;
    while (!(mem_read && mem_addr == 32'h3020) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("pf_inflight_seen", LW'(mem_read && mem_addr == 32'h3020), 1);
    txn(1, 1'b0, 32'h4000);
    drain("pf_blocks_demand");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-client arbiter that multiplexes cache-line requests from several L1 caches onto one downstream memory/L2 port.
- Arbitration is round-robin, and each grant is held until the downstream `mem_resp`.
- An optional next-line prefetch buffer serves one designated client, normally the instruction cache.
- Sits between the L1 caches and the L2 cache / physical-memory interface.

Parameters:
- NUM_CLIENTS, 2, number of requesting clients (2..8).
- ADDR_W, 32, address width.
- LINE_W, 256, cache-line data width.
- LINE_BYTES, 32, line size in bytes; next-line stride.
- PF_CLIENT, 0, client index eligible for prefetch (used only with the prefetch macro).

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cl_read  in  NUM_CLIENTS  per-client read request.
- cl_write  in  NUM_CLIENTS  per-client write request.
- cl_addr  in  NUM_CLIENTS*ADDR_W  per-client line address, packed with client i at [i*ADDR_W +: ADDR_W].
- cl_wdata  in  NUM_CLIENTS*LINE_W  per-client write line, packed.
- cl_rdata  out  LINE_W  read line, shared by all clients; valid only with a resp bit.
- cl_resp  out  NUM_CLIENTS  one-hot completion strobe.
- mem_read  out  1  downstream read.
- mem_write  out  1  downstream write.
- mem_addr  out  ADDR_W  downstream address.
- mem_wdata  out  LINE_W  downstream write data.
- mem_rdata  in  LINE_W  downstream read data.
- mem_resp  in  1  downstream completion.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0, grant=0.
  - All mem_* and cl_* outputs 0.
  - Prefetch buffer invalid.
  - Reset asserted mid-transaction drops mem_read/mem_write immediately; no response is delivered.
- States: IDLE, SERVE; plus PREFETCH and PF_HIT when the macro is enabled.
- IDLE:
  - A client is requesting if cl_read[i] or cl_write[i] is set.
  - Pick the first requesting client starting at rr_ptr, wrapping modulo NUM_CLIENTS.
  - Latch grant index, op, addr and wdata; go to SERVE.
  - No request means stay in IDLE.
  - IDLE lasts at least 1 cycle between transactions. This prevents re-granting a request that was already answered.
- SERVE:
  - mem_read/mem_write/mem_addr/mem_wdata are driven from the latched values, so they are stable for the whole transaction.
  - On mem_resp: cl_resp[grant]=1 and cl_rdata=mem_rdata in the same cycle (combinational pass-through).
  - Then rr_ptr<=(grant+1) mod NUM_CLIENTS; go to IDLE.
  - Latency: grant 1 cycle after request seen; response in the same cycle as mem_resp.
- Handshake rules:
  - A client holds its request and address until it sees its resp bit, and deasserts the following cycle.
  - A request withdrawn before resp is not aborted. The transaction completes and its resp is still pulsed.
  - Read and write asserted together by one client: the write is performed and the read is ignored.
- Fairness: with all clients requesting continuously, grants rotate 0,1,…,N-1,0. No client waits more than N-1 transactions.
- Unused or out-of-range rr_ptr values are impossible; rr_ptr width is $clog2(NUM_CLIENTS), clamped for N=1.

Optional Feature:
- Macro: MEM_ARB_PREFETCH_EN.
- Enabled, state and capture:
  - One-line buffer: pf_valid, pf_tag (line address), pf_data.
  - After a SERVE read for PF_CLIENT at line A, if IDLE sees no requests, issue a read of A+LINE_BYTES (aligned, wraps modulo 2^ADDR_W) in PREFETCH.
  - On mem_resp in PREFETCH, capture the line, set pf_valid, return to IDLE.
  - PREFETCH is non-abortable: demand requests wait, and no cl_resp is produced for a prefetch.
- Enabled, hits and invalidation:
  - In IDLE, a PF_CLIENT read whose line address equals pf_tag with pf_valid set gets priority over rr.
  - It goes to PF_HIT and is answered next cycle: cl_resp[PF_CLIENT]=1, cl_rdata=pf_data, no memory access. rr_ptr is unchanged.
  - Any client write whose line address equals pf_tag clears pf_valid when granted.
  - A prefetch never re-fetches a line already held valid.
- Disabled: no buffer and no PREFETCH/PF_HIT states; pure round-robin.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum arb_state_e.
  - LINE_OFFSET_W = $clog2(LINE_BYTES).
  - A line-align helper function.
- One sub-module, rr_priority_picker: combinational; inputs are the request vector and rr_ptr; outputs are the found flag and the index.

Test Plan:
1. N=2, client 1 read 0x100 only; mem_resp after 3 cycles with 0xAA..AA → mem_read=1, mem_addr=0x100 for 3 cycles; cl_resp=2'b10 with cl_rdata=0xAA..AA; rr_ptr=0.
2. N=4, all clients request continuously for 8 transactions → grant order 0,1,2,3,0,1,2,3; ≥1 IDLE cycle between grants.
3. Client 0 write 0x40 and client 1 read 0x80 in the same cycle, rr_ptr=0 → write 0x40 issued first, then read 0x80; cl_resp pulses 01, then 10.
4. rst_n low during SERVE with mem_read=1 → mem_read=0 the same cycle, no cl_resp; after release the first grant goes to client 0.
5. MEM_ARB_PREFETCH_EN: client 0 read 0x1000, then idle → mem_read at 0x1020 with no cl_resp. Next client 0 read 0x1020 → cl_resp[0] one cycle later, no mem_read. Client 1 write 0x1020 beforehand → miss, normal SERVE.
6. Prefetch in flight when client 1 requests → client 1 granted only after the prefetch mem_resp.
